avalon_mic_array: RTL

Avalon-MM slave that deserialises NUM_MICS stereo I2S microphone lanes and assembles complete left/right frames. All lanes share one sck/ws pair, and the bus is oversampled in the CLK domain. Frames are buffered in a FIFO that software reads and pops through a register map, which lets software run the mic array without missing samples. A live or FIFO-head sample pair of mic 0 is exported to the codec path.

---
 rtl/avalon_mic_pkg.sv | 24 ++
 rtl/i2s_rx_lane.sv | 45 ++++
 rtl/avalon_mic_array.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_mic_pkg.sv
// Shared register map, control/status bit positions and size limits for the I2S mic array.
// Pure constants: no logic, no latency, no flow control.
package avalon_mic_pkg;

  localparam int MAX_MICS = 8;

  localparam logic [4:0] ADDR_CTRL        = 5'd0;
  localparam logic [4:0] ADDR_STATUS      = 5'd1;
  localparam logic [4:0] ADDR_FRAME_CNT   = 5'd2;
  localparam logic [4:0] ADDR_POP         = 5'd3;
  localparam logic [4:0] ADDR_IRQ_THR     = 5'd4;
  localparam logic [4:0] ADDR_SAMPLE_BASE = 5'd8;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_FLUSH    = 1;
  localparam int CTRL_LIVE_SEL = 2;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_UDF     = 3;
  localparam int STAT_LVL_LSB = 8;

endpackage

// File: rtl/i2s_rx_lane.sv
// One sd lane: MSB-first shift register plus left/right holding registers.
// Word lands in its holding register on the cycle after i_cap; no backpressure, strobes come from the top.
module i2s_rx_lane
  import avalon_mic_pkg::*;
#(
  parameter int SAMPLE_W = 18
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_shift_en,
  input  logic                i_cap,
  input  logic                i_ws,
  input  logic                i_sd,
  output logic [SAMPLE_W-1:0] o_left,
  output logic [SAMPLE_W-1:0] o_right
);

  logic [SAMPLE_W-1:0] r_shift;
  logic [SAMPLE_W-1:0] r_left;
  logic [SAMPLE_W-1:0] r_right;
  logic [SAMPLE_W-1:0] w_word;
  logic                w_unused;

  // The final bit is merged in directly so the complete word is available on the capture edge.
  assign w_word   = {r_shift[SAMPLE_W-2:0], i_sd};
  assign w_unused = r_shift[SAMPLE_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_left  <= '0;
      r_right <= '0;
    end else begin
      if (i_shift_en) r_shift <= w_word;
      if (i_cap) begin
        if (i_ws) r_right <= w_word;
        else      r_left  <= w_word;
      end
    end
  end

  assign o_left  = r_left;
  assign o_right = r_right;

endmodule

// File: rtl/avalon_mic_array.sv
// Avalon-MM I2S mic array: oversampled sck/ws/sd, frame FIFO popped by register writes, zero-wait reads.
// Frames are dropped (OVF) when the FIFO is full; define AVL_MIC_IRQ_EN for the level/overflow irq.
module avalon_mic_array
  import avalon_mic_pkg::*;
#(
  parameter int NUM_MICS   = 4,
  parameter int SAMPLE_W   = 18,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  AVL_READ,
  input  logic                  AVL_WRITE,
  input  logic                  AVL_CS,
  input  logic [4:0]            AVL_ADDR,
  input  logic [31:0]           AVL_WRITEDATA,
  output logic [31:0]           AVL_READDATA,
  input  logic                  sck,
  input  logic                  ws,
  input  logic [NUM_MICS-1:0]   sd,
  output logic [2*SAMPLE_W-1:0] lrout
`ifdef AVL_MIC_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = NUM_MICS * 2 * SAMPLE_W;

  logic [1:0]          r_sck_sync;
  logic [1:0]          r_ws_sync;
  logic [NUM_MICS-1:0] r_sd_s1;
  logic [NUM_MICS-1:0] r_sd_s2;
  logic                r_sck_dly;
  logic                r_ws_prev;
  logic [5:0]          r_cnt;
  logic                r_armed;
  logic                r_vld_l;
  logic                r_vld_r;

  logic                r_enable;
  logic                r_live_sel;
  logic                r_ovf;
  logic                r_udf;
  logic [31:0]         r_frame_cnt;

  logic [FW-1:0]       r_mem [FIFO_DEPTH];
  logic [AW:0]         r_wr_ptr;
  logic [AW:0]         r_rd_ptr;

  logic                w_sck_s;
  logic                w_ws_s;
  logic                w_edge;
  logic                w_ws_diff;
  logic                w_shift_en;
  logic                w_cap;
  logic                w_push_req;
  logic                w_wr;
  logic                w_rd;
  logic                w_flush;
  logic                w_pop_req;
  logic                w_stat_wr;
  logic                w_do_push;
  logic                w_do_pop;
  logic                w_ovf_set;
  logic                w_udf_set;
  logic [AW:0]         w_level;
  logic                w_empty;
  logic                w_full;
  logic [FW-1:0]       w_frame;
  logic [FW-1:0]       w_head;
  logic [4:0]          w_sel;
  logic [3:0]          w_mic;
  logic [SAMPLE_W-1:0] w_sample;
  logic                w_hit;
  logic [31:0]         w_rdata;
  logic                w_unused;
  logic [SAMPLE_W-1:0] w_left  [NUM_MICS];
  logic [SAMPLE_W-1:0] w_right [NUM_MICS];

  assign w_sck_s   = r_sck_sync[1];
  assign w_ws_s    = r_ws_sync[1];
  assign w_edge    = w_sck_s & ~r_sck_dly;
  assign w_ws_diff = w_ws_s ^ r_ws_prev;

  // Shifting only starts after a slot boundary has been seen while enabled, so partial slots never capture.
  assign w_shift_en = w_edge & r_enable & r_armed & ~w_ws_diff & (r_cnt < 6'(SAMPLE_W));
  assign w_cap      = w_shift_en & (r_cnt == 6'(SAMPLE_W - 1));
  assign w_push_req = w_edge & w_ws_diff & ~w_ws_s & r_enable & r_vld_l & r_vld_r;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sck_sync <= '0;
      r_ws_sync  <= '0;
      r_sd_s1    <= '0;
      r_sd_s2    <= '0;
      r_sck_dly  <= 1'b0;
      r_ws_prev  <= 1'b0;
      r_cnt      <= '0;
      r_armed    <= 1'b0;
      r_vld_l    <= 1'b0;
      r_vld_r    <= 1'b0;
    end else begin
      r_sck_sync <= {r_sck_sync[0], sck};
      r_ws_sync  <= {r_ws_sync[0], ws};
      r_sd_s1    <= sd;
      r_sd_s2    <= r_sd_s1;
      r_sck_dly  <= w_sck_s;
      if (w_edge) r_ws_prev <= w_ws_s;
      if (!r_enable) begin
        r_cnt   <= '0;
        r_armed <= 1'b0;
        r_vld_l <= 1'b0;
        r_vld_r <= 1'b0;
      end else if (w_edge) begin
        if (w_ws_diff) begin
          r_cnt   <= '0;
          r_armed <= 1'b1;
          if (!w_ws_s) begin
            r_vld_l <= 1'b0;
            r_vld_r <= 1'b0;
          end
        end else if (w_shift_en) begin
          r_cnt <= r_cnt + 6'd1;
          if (w_cap) begin
            if (w_ws_s) r_vld_r <= 1'b1;
            else        r_vld_l <= 1'b1;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_MICS; g++) begin : g_lane
    i2s_rx_lane #(.SAMPLE_W(SAMPLE_W)) u_lane (
      .clk       (CLK),
      .rst       (RESET),
      .i_shift_en(w_shift_en),
      .i_cap     (w_cap),
      .i_ws      (w_ws_s),
      .i_sd      (r_sd_s2[g]),
      .o_left    (w_left[g]),
      .o_right   (w_right[g])
    );
    assign w_frame[g*2*SAMPLE_W +: 2*SAMPLE_W] = {w_left[g], w_right[g]};
  end

  assign w_wr      = AVL_CS & AVL_WRITE;
  assign w_rd      = AVL_CS & AVL_READ;
  assign w_flush   = w_wr && (AVL_ADDR == ADDR_CTRL) && AVL_WRITEDATA[CTRL_FLUSH];
  assign w_pop_req = w_wr && (AVL_ADDR == ADDR_POP);
  assign w_stat_wr = w_wr && (AVL_ADDR == ADDR_STATUS);

  assign w_level = r_wr_ptr - r_rd_ptr;
  assign w_empty = (w_level == '0);
  assign w_full  = (w_level == (AW+1)'(FIFO_DEPTH));
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

  // A full FIFO still accepts a push when the same cycle pops; an empty FIFO never pops.
  assign w_do_push = w_push_req & ~w_flush & (~w_full | w_pop_req);
  assign w_do_pop  = w_pop_req & ~w_empty & ~w_flush;
  assign w_ovf_set = w_push_req & ~w_flush & w_full & ~w_pop_req;
  assign w_udf_set = w_pop_req & w_empty;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_flush) begin
      r_rd_ptr <= r_wr_ptr;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= w_frame;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_enable    <= 1'b0;
      r_live_sel  <= 1'b0;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (w_wr && (AVL_ADDR == ADDR_CTRL)) begin
        r_enable   <= AVL_WRITEDATA[CTRL_ENABLE];
        r_live_sel <= AVL_WRITEDATA[CTRL_LIVE_SEL];
      end
      r_ovf <= w_ovf_set | (r_ovf & ~(w_stat_wr & AVL_WRITEDATA[STAT_OVF]));
      r_udf <= w_udf_set | (r_udf & ~(w_stat_wr & AVL_WRITEDATA[STAT_UDF]));
      if (w_push_req) r_frame_cnt <= r_frame_cnt + 32'd1;
    end
  end

`ifdef AVL_MIC_IRQ_EN
  logic [7:0] r_irq_thr;
  logic       r_irq;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_irq_thr <= 8'd1;
      r_irq     <= 1'b0;
    end else begin
      if (w_wr && (AVL_ADDR == ADDR_IRQ_THR)) r_irq_thr <= AVL_WRITEDATA[7:0];
      r_irq <= ((r_irq_thr != 8'd0) && (8'(w_level) >= r_irq_thr)) || r_ovf;
    end
  end

  assign irq      = r_irq;
  assign w_unused = ^AVL_WRITEDATA[31:8];
`else
  assign w_unused = ^AVL_WRITEDATA[31:4];
`endif

  assign w_sel = AVL_ADDR - ADDR_SAMPLE_BASE;
  assign w_mic = w_sel[4:1];

  always_comb begin
    w_rdata  = '0;
    w_sample = '0;
    w_hit    = 1'b0;
    case (AVL_ADDR)
      ADDR_CTRL: begin
        w_rdata[CTRL_ENABLE]   = r_enable;
        w_rdata[CTRL_LIVE_SEL] = r_live_sel;
      end
      ADDR_STATUS: begin
        w_rdata[STAT_EMPTY]                = w_empty;
        w_rdata[STAT_FULL]                 = w_full;
        w_rdata[STAT_OVF]                  = r_ovf;
        w_rdata[STAT_UDF]                  = r_udf;
        w_rdata[STAT_LVL_LSB +: 8]         = 8'(w_level);
      end
      ADDR_FRAME_CNT: w_rdata = r_frame_cnt;
`ifdef AVL_MIC_IRQ_EN
      ADDR_IRQ_THR:   w_rdata[7:0] = r_irq_thr;
`endif
      default: begin
        // Within a lane's pair, left sits in the upper half and right in the lower half.
        if (AVL_ADDR >= ADDR_SAMPLE_BASE && !w_empty) begin
          for (int i = 0; i < NUM_MICS; i++) begin
            if (w_mic == 4'(i)) begin
              w_hit    = 1'b1;
              w_sample = w_sel[0] ? w_head[i*2*SAMPLE_W +: SAMPLE_W]
                                  : w_head[i*2*SAMPLE_W + SAMPLE_W +: SAMPLE_W];
            end
          end
          if (w_hit) w_rdata = 32'($signed(w_sample));
        end
      end
    endcase
  end

  assign AVL_READDATA = w_rd ? w_rdata : 32'd0;

  assign lrout = r_live_sel ? {w_left[0], w_right[0]}
               : (w_empty ? '0 : w_head[2*SAMPLE_W-1:0]);

endmodule
